// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with a persistent flag register.
// Single-cycle logic and arithmetic ops, iterative shift, and an optional
// shift-add multiply that is compiled in when ALU_MUL_EN is defined.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid/in_ready  request handshake (ready only while idle)
//   Opcode, Src, Dest  operation select and operands, latched on accept
//   C                  registered result
//   Flags              {N, Z, F, L, C} registered flags
//   done               one-cycle pulse when C/Flags are updated
//   err                one-cycle pulse alongside done for an undefined opcode
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       Opcode,
  input  logic [WIDTH-1:0] Src,
  input  logic [WIDTH-1:0] Dest,
  output logic [WIDTH-1:0] C,
  output logic [4:0]       Flags,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_SHIFT,
    S_MUL
  } state_e;

  typedef enum logic [7:0] {
    OP_AND  = 8'h01,
    OP_OR   = 8'h02,
    OP_XOR  = 8'h03,
    OP_ADD  = 8'h05,
    OP_ADDU = 8'h06,
    OP_ADDC = 8'h07,
    OP_SUB  = 8'h09,
    OP_CMP  = 8'h0B,
    OP_MOV  = 8'h0D,
    OP_MUL  = 8'h0E,
    OP_LSH  = 8'h84
  } op_e;

  localparam int FC = 0;
  localparam int FL = 1;
  localparam int FF = 2;
  localparam int FZ = 3;
  localparam int FN = 4;

  localparam logic [SHW-1:0] CNT_W = SHW'(WIDTH);
  localparam logic [SHW-1:0] CNT_1 = SHW'(1);

  state_e           state_q,    state_d;
  logic [7:0]       op_q,       op_d;
  logic [WIDTH-1:0] src_q,      src_d;
  logic [WIDTH-1:0] dest_q,     dest_d;
  logic [WIDTH-1:0] work_q,     work_d;
  logic [SHW-1:0]   cnt_q,      cnt_d;
  logic             dir_q,      dir_d;
  logic [WIDTH-1:0] c_q,        c_d;
  logic [4:0]       flags_q,    flags_d;
  logic             done_q,     done_d;
  logic             err_q,      err_d;
  logic             in_ready_q, in_ready_d;

  // Shift-amount decode on the incoming operand
  logic [SHW-1:0]   amt;
  logic [SHW-1:0]   amt_mag;
  logic [SHW-1:0]   shift_cnt;

  // Single-cycle datapath on the latched operands
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_dif;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] sh_next;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_lo;
`endif

  assign in_ready = in_ready_q;
  assign C        = c_q;
  assign Flags    = flags_q;
  assign done     = done_q;
  assign err      = err_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    src_d      = src_q;
    dest_d     = dest_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    c_d        = c_q;
    flags_d    = flags_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    in_ready_d = in_ready_q;
`ifdef ALU_MUL_EN
    hi_d       = hi_q;
`endif

    // Amounts beyond WIDTH clamp to WIDTH steps; WIDTH steps already clear the word.
    amt       = Src[SHW-1:0];
    amt_mag   = amt[SHW-1] ? (~amt + CNT_1) : amt;
    shift_cnt = (amt_mag > CNT_W) ? CNT_W : amt_mag;

    add_cin   = (op_q == OP_ADDC) ? flags_q[FC] : 1'b0;
    add_sum   = {1'b0, dest_q} + {1'b0, src_q} + {{WIDTH{1'b0}}, add_cin};
    sub_dif   = {1'b0, dest_q} - {1'b0, src_q};
    add_ovf   = (dest_q[WIDTH-1] == src_q[WIDTH-1]) &&
                (add_sum[WIDTH-1] != dest_q[WIDTH-1]);
    sub_ovf   = (dest_q[WIDTH-1] != src_q[WIDTH-1]) &&
                (sub_dif[WIDTH-1] != dest_q[WIDTH-1]);

    case (op_q)
      OP_AND:  logic_res = dest_q & src_q;
      OP_OR:   logic_res = dest_q | src_q;
      default: logic_res = dest_q ^ src_q;
    endcase

    sh_next = dir_q ? (work_q >> 1) : (work_q << 1);

`ifdef ALU_MUL_EN
    // One shift-add step: conditionally add the multiplicand into the high
    // half, then shift {carry, hi, lo} right by one.
    mul_sum = {1'b0, hi_q} + {1'b0, (work_q[0] ? dest_q : {WIDTH{1'b0}})};
    mul_lo  = {mul_sum[0], work_q[WIDTH-1:1]};
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d       = Opcode;
          src_d      = Src;
          dest_d     = Dest;
          in_ready_d = 1'b0;
          if (Opcode == OP_LSH && shift_cnt != '0) begin
            work_d  = Dest;
            cnt_d   = shift_cnt;
            dir_d   = amt[SHW-1];
            state_d = S_SHIFT;
`ifdef ALU_MUL_EN
          end else if (Opcode == OP_MUL) begin
            work_d  = Src;
            hi_d    = '0;
            cnt_d   = CNT_W;
            state_d = S_MUL;
`endif
          end else begin
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        done_d     = 1'b1;
        in_ready_d = 1'b1;
        state_d    = S_IDLE;
        case (op_q)
          OP_AND, OP_OR, OP_XOR: begin
            c_d         = logic_res;
            flags_d[FZ] = (logic_res == '0);
            flags_d[FN] = logic_res[WIDTH-1];
          end
          OP_ADD, OP_ADDC: begin
            c_d         = add_sum[WIDTH-1:0];
            flags_d[FC] = add_sum[WIDTH];
            flags_d[FF] = add_ovf;
            flags_d[FZ] = (add_sum[WIDTH-1:0] == '0);
          end
          OP_ADDU: begin
            c_d         = add_sum[WIDTH-1:0];
            flags_d[FC] = add_sum[WIDTH];
            flags_d[FZ] = (add_sum[WIDTH-1:0] == '0);
          end
          OP_SUB: begin
            c_d         = sub_dif[WIDTH-1:0];
            flags_d[FC] = sub_dif[WIDTH];
            flags_d[FF] = sub_ovf;
            flags_d[FZ] = (sub_dif[WIDTH-1:0] == '0);
          end
          OP_CMP: begin
            flags_d[FZ] = (dest_q == src_q);
            flags_d[FL] = (dest_q < src_q);
            flags_d[FN] = ($signed(dest_q) < $signed(src_q));
          end
          OP_MOV: begin
            c_d = src_q;
          end
          OP_LSH: begin
            // Only a zero shift amount takes the single-cycle path.
            c_d         = dest_q;
            flags_d[FZ] = (dest_q == '0);
          end
          default: begin
            err_d = 1'b1;
          end
        endcase
      end

      S_SHIFT: begin
        work_d = sh_next;
        cnt_d  = cnt_q - CNT_1;
        if (cnt_q == CNT_1) begin
          c_d         = sh_next;
          flags_d[FZ] = (sh_next == '0);
          done_d      = 1'b1;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

`ifdef ALU_MUL_EN
      S_MUL: begin
        hi_d   = mul_sum[WIDTH:1];
        work_d = mul_lo;
        cnt_d  = cnt_q - CNT_1;
        if (cnt_q == CNT_1) begin
          c_d         = mul_lo;
          flags_d[FF] = (mul_sum[WIDTH:1] != '0);
          flags_d[FZ] = (mul_lo == '0);
          done_d      = 1'b1;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
`endif

      default: begin
        in_ready_d = 1'b1;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      src_q      <= '0;
      dest_q     <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      c_q        <= '0;
      flags_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b1;
`ifdef ALU_MUL_EN
      hi_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src_q      <= src_d;
      dest_q     <= dest_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      c_q        <= c_d;
      flags_q    <= flags_d;
      done_q     <= done_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
`ifdef ALU_MUL_EN
      hi_q       <= hi_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed cases followed by
// random operations, each compared against an arithmetic reference model.
module tb_alu_seq;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  Opcode;
  logic [15:0] Src;
  logic [15:0] Dest;
  logic [15:0] C;
  logic [4:0]  Flags;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  // Reference state: last result and flag register
  logic [15:0] mc;
  logic [4:0]  mf;

  logic [7:0] ops [0:11] = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h07,
                             8'h09, 8'h0B, 8'h0D, 8'h84, 8'h0E, 8'hFF};

  alu_seq #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Opcode   (Opcode),
    .Src      (Src),
    .Dest     (Dest),
    .C        (C),
    .Flags    (Flags),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags bit order: [0] carry/borrow, [1] L, [2] F, [3] Z, [4] N
  task automatic model(input logic [7:0] op, input logic [15:0] s, input logic [15:0] d,
                       output logic [15:0] ec, output logic [4:0] ef,
                       output logic ee, output int lat);
    int sd, ss, sum, cin, a, m;
    logic [31:0] p;
    ec = mc; ef = mf; ee = 1'b0; lat = 1;
    sd = $signed(d);
    ss = $signed(s);
    case (op)
      8'h01, 8'h02, 8'h03: begin
        ec = (op == 8'h01) ? (d & s) : (op == 8'h02) ? (d | s) : (d ^ s);
        ef[3] = (ec == 16'h0);
        ef[4] = ec[15];
      end
      8'h05, 8'h06, 8'h07: begin
        cin = (op == 8'h07) ? int'(mf[0]) : 0;
        sum = int'(d) + int'(s) + cin;
        ec = sum[15:0];
        ef[0] = (sum > 65535);
        if (op != 8'h06) ef[2] = (sd + ss + cin > 32767) || (sd + ss + cin < -32768);
        ef[3] = (ec == 16'h0);
      end
      8'h09: begin
        ec = d - s;
        ef[0] = (d < s);
        ef[2] = (sd - ss > 32767) || (sd - ss < -32768);
        ef[3] = (ec == 16'h0);
      end
      8'h0B: begin
        ef[3] = (d == s);
        ef[1] = (d < s);
        ef[4] = (sd < ss);
      end
      8'h0D: ec = s;
      8'h84: begin
        a = s[4] ? int'(s[4:0]) - 32 : int'(s[4:0]);
        m = (a < 0) ? -a : a;
        if (m == 0) ec = d;
        else begin
          lat = (m > 16) ? 16 : m;
          if (m >= 16) ec = 16'h0;
          else if (a > 0) ec = d << m;
          else ec = d >> m;
        end
        ef[3] = (ec == 16'h0);
      end
      8'h0E: begin
        if (MUL_EN) begin
          p = {16'h0, d} * {16'h0, s};
          ec = p[15:0];
          ef[2] = (p[31:16] != 16'h0);
          ef[3] = (ec == 16'h0);
          lat = 16;
        end else ee = 1'b1;
      end
      default: ee = 1'b1;
    endcase
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic do_op(input string tag, input logic [7:0] op,
                       input logic [15:0] s, input logic [15:0] d);
    logic [15:0] ec;
    logic [4:0]  ef;
    logic        ee;
    logic        busy_ok;
    int          lat, cyc;
    model(op, s, d, ec, ef, ee, lat);
    chk({tag, ":ready_before"}, in_ready, 1);
    in_valid = 1'b1; Opcode = op; Src = s; Dest = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    Opcode = 8'($urandom); Src = 16'($urandom); Dest = 16'($urandom);
    cyc = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 100) begin
      if (in_ready !== 1'b0 || err !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, ":busy"}, busy_ok, 1);
    chk({tag, ":latency"}, cyc, lat);
    chk({tag, ":C"}, C, ec);
    chk({tag, ":Flags"}, Flags, ef);
    chk({tag, ":err"}, err, ee);
    chk({tag, ":ready_after"}, in_ready, 1);
    mc = ec;
    mf = ef;
  endtask

  initial begin
    logic saw_done;
    logic [7:0] op;
    int sel;

    rst_n = 1'b0; in_valid = 1'b1; Opcode = 8'h05; Src = 16'h1; Dest = 16'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset:C", C, 0);
    chk("reset:Flags", Flags, 0);
    chk("reset:done", done, 0);
    chk("reset:err", err, 0);
    chk("reset:ready", in_ready, 1);
    mc = 16'h0; mf = 5'h0;
    rst_n = 1'b1;

    do_op("add_ovf",  8'h05, 16'h0001, 16'h7FFF);
    do_op("addc_wrap", 8'h07, 16'h0001, 16'hFFFF);
    do_op("addc_cin", 8'h07, 16'h0000, 16'h0000);
    do_op("cmp",      8'h0B, 16'h0001, 16'hFFFE);
    do_op("sub",      8'h09, 16'h0007, 16'h0005);
    do_op("addu",     8'h06, 16'h8000, 16'h8000);
    do_op("and",      8'h01, 16'hF0F0, 16'h8F0F);
    do_op("mov",      8'h0D, 16'h1234, 16'h0000);
    do_op("lsh_l5",   8'h84, 16'h0005, 16'h0001);
    do_op("lsh_r3",   8'h84, 16'h001D, 16'h8000);
    do_op("lsh_0",    8'h84, 16'h0000, 16'hBEEF);
    do_op("lsh_l15",  8'h84, 16'h000F, 16'h0001);
    do_op("lsh_r16",  8'h84, 16'h0010, 16'hFFFF);
    do_op("mul",      8'h0E, 16'h0100, 16'h0100);
    do_op("mul2",     8'h0E, 16'h0003, 16'h0005);
    do_op("undef",    8'hFF, 16'h1111, 16'h2222);

    // Reset three cycles into a five-step shift must abort it silently.
    in_valid = 1'b1; Opcode = 8'h84; Src = 16'h0005; Dest = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    saw_done = 1'b0;
    repeat (2) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    if (done === 1'b1) saw_done = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset:C", C, 0);
    chk("midreset:Flags", Flags, 0);
    chk("midreset:ready", in_ready, 1);
    rst_n = 1'b1;
    repeat (5) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("midreset:no_done", saw_done, 0);
    mc = 16'h0; mf = 5'h0;

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 12);
      op = (sel == 12) ? 8'($urandom) : ops[sel];
      do_op("rand", op, 16'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
